// File: rtl/fifo_access_scheduler_pkg.sv
// Shared types and default constants for the FIFO access scheduler.
package fifo_sched_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR   = 2'd1,
    RD   = 2'd2
  } state_e;

  localparam int DEF_INDEX_WIDTH = 5;
  localparam int DEF_MAX_BURST   = 4;
  localparam int DEF_AF_SLOTS    = 4;
endpackage

// File: rtl/fifo_access_scheduler_if.sv
// Producer/consumer/FIFO-pin bundle for the FIFO access scheduler.
// master: scheduler side. slave: surrounding logic / FIFO side.
// With FIFO_SCHED_CHECK_EN defined, the FIFO flags and sched_err are added.
interface fifo_access_scheduler_if #(
  parameter int NUM_PROD    = 4,
  parameter int INDEX_WIDTH = fifo_sched_pkg::DEF_INDEX_WIDTH
);
  logic [NUM_PROD-1:0]         prod_valid;
  logic [8*NUM_PROD-1:0]       prod_data;
  logic [NUM_PROD-1:0]         prod_ready;
  logic                        cons_req;
  logic                        cons_ready;
  logic                        fifo_wr_en;
  logic [7:0]                  fifo_wr_data;
  logic                        fifo_rd_req;
  logic [$clog2(NUM_PROD)-1:0] grant_id;
  logic [INDEX_WIDTH:0]        occupancy;
`ifdef FIFO_SCHED_CHECK_EN
  logic                        fifo_empty;
  logic                        fifo_full;
  logic                        sched_err;

  modport master (
    input  prod_valid, prod_data, cons_req, fifo_empty, fifo_full,
    output prod_ready, cons_ready, fifo_wr_en, fifo_wr_data, fifo_rd_req,
           grant_id, occupancy, sched_err
  );
  modport slave (
    output prod_valid, prod_data, cons_req, fifo_empty, fifo_full,
    input  prod_ready, cons_ready, fifo_wr_en, fifo_wr_data, fifo_rd_req,
           grant_id, occupancy, sched_err
  );
`else
  modport master (
    input  prod_valid, prod_data, cons_req,
    output prod_ready, cons_ready, fifo_wr_en, fifo_wr_data, fifo_rd_req,
           grant_id, occupancy
  );
  modport slave (
    output prod_valid, prod_data, cons_req,
    input  prod_ready, cons_ready, fifo_wr_en, fifo_wr_data, fifo_rd_req,
           grant_id, occupancy
  );
`endif
endinterface

// File: rtl/fifo_access_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after the pointer.
module rr_arbiter #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] i_req,
  input  logic [W-1:0] i_ptr,
  output logic [W-1:0] o_win,
  output logic         o_any
);
  logic [W:0] w_idx;

  // scan upward from the pointer with wrap at N; the first requester wins
  always_comb begin
    o_win = '0;
    o_any = 1'b0;
    w_idx = '0;
    for (int i = 0; i < N; i++) begin
      w_idx = {1'b0, i_ptr} + (W+1)'(i);
      if (w_idx >= (W+1)'(N)) w_idx = w_idx - (W+1)'(N);
      if (!o_any && i_req[w_idx[W-1:0]]) begin
        o_win = w_idx[W-1:0];
        o_any = 1'b1;
      end
    end
  end
endmodule

// File: rtl/fifo_access_scheduler.sv
// FIFO access scheduler: shares one FIFO write port among NUM_PROD producers
// (round-robin, bounded bursts) and serves the read port, never strobing
// both in one cycle. Occupancy is tracked locally, not from FIFO flags.
// Optional FIFO_SCHED_CHECK_EN: cross-checks local count against the FIFO's
// empty/full flags and raises a sticky sched_err.
module fifo_access_scheduler
  import fifo_sched_pkg::*;
#(
  parameter int NUM_PROD    = 4,
  parameter int INDEX_WIDTH = DEF_INDEX_WIDTH,
  parameter int DEPTH       = 1 << INDEX_WIDTH,
  parameter int MAX_BURST   = DEF_MAX_BURST,
  parameter int AF_SLOTS    = DEF_AF_SLOTS
) (
  input logic                     clk,
  input logic                     reset,
  fifo_access_scheduler_if.master bus
);
  localparam int GW = $clog2(NUM_PROD);
  localparam int OW = INDEX_WIDTH + 1;
  localparam int BW = $clog2(MAX_BURST + 1);

  state_e              r_state, w_nstate;
  logic [OW-1:0]       r_occ, w_free;
  logic [GW-1:0]       r_rr, r_gid, w_win;
  logic [BW-1:0]       r_burst;
  logic                r_wr_en, r_rd_req;
  logic [7:0]          r_wr_data;
  logic                w_any, w_wr_xfer, w_rd_xfer, w_exit, w_last, w_cons_ready;
  logic [NUM_PROD-1:0] w_prod_ready;

  assign w_free = OW'(DEPTH) - r_occ;
  assign w_last = (r_burst == BW'(MAX_BURST - 1));

  rr_arbiter #(.N(NUM_PROD), .W(GW)) u_arb (
    .i_req (bus.prod_valid),
    .i_ptr (r_rr),
    .o_win (w_win),
    .o_any (w_any)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_nstate;
  end

  // next state, handshake readies and transfer qualifiers
  always_comb begin
    w_nstate     = r_state;
    w_prod_ready = '0;
    w_cons_ready = 1'b0;
    w_wr_xfer    = 1'b0;
    w_rd_xfer    = 1'b0;
    w_exit       = 1'b0;
    case (r_state)
      IDLE: begin
        // reads win when nearly full or nobody wants to write
        if (bus.cons_req && r_occ != '0 && (w_free < OW'(AF_SLOTS) || !w_any))
          w_nstate = RD;
        else if (w_any && w_free != '0)
          w_nstate = WR;
        else if (bus.cons_req && r_occ != '0)
          w_nstate = RD;
      end
      WR: begin
        w_prod_ready[r_gid] = (w_free != '0);
        w_wr_xfer = bus.prod_valid[r_gid] && (w_free != '0);
        // free-after-transfer < AF_SLOTS  <=>  free <= AF_SLOTS
        w_exit = !bus.prod_valid[r_gid] || (w_free == '0) ||
                 (w_wr_xfer && (w_last || w_free == OW'(1) ||
                                (bus.cons_req && w_free <= OW'(AF_SLOTS))));
      end
      RD: begin
        w_cons_ready = (r_occ != '0);
        w_rd_xfer = bus.cons_req && (r_occ != '0);
        w_exit = !bus.cons_req || (r_occ == '0) ||
                 (w_rd_xfer && (w_last || r_occ == OW'(1)));
      end
      default: w_nstate = IDLE;
    endcase
    if (w_exit) w_nstate = IDLE;
    // nothing is offered while reset is held, whatever state we are in
    if (reset) begin
      w_prod_ready = '0;
      w_cons_ready = 1'b0;
    end
  end

  // strobes, write data, occupancy, burst count, grant and rr pointer
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_en   <= 1'b0;
      r_rd_req  <= 1'b0;
      r_wr_data <= '0;
      r_occ     <= '0;
      r_burst   <= '0;
      r_gid     <= '0;
      r_rr      <= '0;
    end else begin
      r_wr_en  <= w_wr_xfer;
      r_rd_req <= w_rd_xfer;
      if (w_wr_xfer) begin
        r_wr_data <= bus.prod_data[8*r_gid +: 8];
        r_occ     <= r_occ + OW'(1);
      end else if (w_rd_xfer) begin
        r_occ <= r_occ - OW'(1);
      end
      if (r_state == IDLE && w_nstate == WR) r_gid <= w_win;
      if (w_exit) begin
        r_burst <= '0;
        if (r_state == WR)
          r_rr <= (r_gid == GW'(NUM_PROD - 1)) ? '0 : r_gid + GW'(1);
      end else if (w_wr_xfer || w_rd_xfer) begin
        r_burst <= r_burst + BW'(1);
      end
    end
  end

  assign bus.prod_ready   = w_prod_ready;
  assign bus.cons_ready   = w_cons_ready;
  assign bus.fifo_wr_en   = r_wr_en;
  assign bus.fifo_rd_req  = r_rd_req;
  assign bus.fifo_wr_data = r_wr_data;
  assign bus.grant_id     = r_gid;
  assign bus.occupancy    = r_occ;

`ifdef FIFO_SCHED_CHECK_EN
  logic [OW-1:0] r_occ_d;
  logic          r_sched_err;

  // FIFO commits a strobe one edge after our count moves, so compare its
  // flags against the count delayed by one cycle; error is sticky
  always_ff @(posedge clk) begin
    if (reset) begin
      r_occ_d     <= '0;
      r_sched_err <= 1'b0;
    end else begin
      r_occ_d <= r_occ;
      if (((r_occ_d == '0) != bus.fifo_empty) ||
          ((r_occ_d == OW'(DEPTH)) != bus.fifo_full))
        r_sched_err <= 1'b1;
    end
  end

  assign bus.sched_err = r_sched_err;
`endif
endmodule

// File: tb/tb_fifo_access_scheduler.sv
// Directed bench for fifo_access_scheduler (NUM_PROD=4, DEPTH=32, MAX_BURST=4).
module tb_fifo_access_scheduler;
  localparam int NP    = 4;
  localparam int IW    = 5;
  localparam int DEPTH = 32;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  fifo_access_scheduler_if #(.NUM_PROD(NP), .INDEX_WIDTH(IW)) bus ();
  fifo_access_scheduler #(.NUM_PROD(NP), .INDEX_WIDTH(IW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int m_occ = 0;
  int rd_cnt = 0;
  int rd0, n0;
  logic [7:0] wq[$];
  int gq[$];
  int wt[$];
  int p_cnt[NP];
  int p_lim[NP];
  logic [7:0] p_base[NP];

`ifdef FIFO_SCHED_CHECK_EN
  int   fcnt;
  logic force_e = 1'b0;
  always @(posedge clk) begin
    if (reset) fcnt <= 0;
    else fcnt <= fcnt + (bus.fifo_wr_en ? 1 : 0) - (bus.fifo_rd_req ? 1 : 0);
  end
  assign bus.fifo_empty = (fcnt == 0) ^ force_e;
  assign bus.fifo_full  = (fcnt == DEPTH);
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // strobe log plus invariants checked every cycle
  always @(negedge clk) begin
    if (reset) begin
      m_occ = 0;
    end else begin
      if (bus.fifo_wr_en) begin
        wq.push_back(bus.fifo_wr_data);
        gq.push_back(int'(bus.grant_id));
        wt.push_back(cyc);
      end
      if (bus.fifo_rd_req) rd_cnt++;
      m_occ = m_occ + (bus.fifo_wr_en ? 1 : 0) - (bus.fifo_rd_req ? 1 : 0);
      chk("strobe_excl", 32'(bus.fifo_wr_en & bus.fifo_rd_req), 32'h0);
      chk("occ_track", 32'(bus.occupancy), 32'(m_occ));
      if (bus.occupancy == 6'(DEPTH)) chk("full_no_ready", 32'(bus.prod_ready), 32'h0);
      if (bus.occupancy == 6'd0) chk("empty_no_cready", 32'(bus.cons_ready), 32'h0);
    end
  end

  task automatic drive();
    for (int p = 0; p < NP; p++) begin
      bus.prod_valid[p] = (p_cnt[p] < p_lim[p]);
      bus.prod_data[8*p +: 8] = p_base[p] + 8'(p_cnt[p]);
    end
  endtask

  // advance n clocks; producers step to their next byte on each accept
  task automatic cycle(input int n);
    logic [NP-1:0] hs;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      hs = bus.prod_valid & bus.prod_ready;
      @(posedge clk);
      #1;
      for (int p = 0; p < NP; p++) if (hs[p]) p_cnt[p]++;
      drive();
      #1;
    end
  endtask

  initial begin
    bus.prod_valid = '0;
    bus.prod_data  = '0;
    bus.cons_req   = 1'b0;
    for (int p = 0; p < NP; p++) begin
      p_cnt[p] = 0; p_lim[p] = 0; p_base[p] = 8'h00;
    end
    reset = 1'b1;
    cycle(2);
    chk("rst_wr_en",  32'(bus.fifo_wr_en),   32'h0);
    chk("rst_rd_req", 32'(bus.fifo_rd_req),  32'h0);
    chk("rst_occ",    32'(bus.occupancy),    32'h0);
    chk("rst_gid",    32'(bus.grant_id),     32'h0);
    chk("rst_wdata",  32'(bus.fifo_wr_data), 32'h0);
    chk("rst_pready", 32'(bus.prod_ready),   32'h0);
    chk("rst_cready", 32'(bus.cons_ready),   32'h0);

    // producer 2 alone, six bytes: burst of 4, bubble, then 2
    p_base[2] = 8'h11; p_lim[2] = 6;
    reset = 1'b0; drive(); #1;
    cycle(1);
    chk("t1_ready_lat", 32'(bus.prod_ready), 32'h4);
    chk("t1_no_wr_yet", 32'(bus.fifo_wr_en), 32'h0);
    cycle(1);
    chk("t1_wr_lat", 32'(bus.fifo_wr_en),   32'h1);
    chk("t1_wdata0", 32'(bus.fifo_wr_data), 32'h11);
    cycle(10);
    chk("t1_count", 32'(wq.size()), 32'd6);
    for (int i = 0; i < 6; i++) begin
      chk("t1_data", 32'(wq[i]), 32'h11 + 32'(i));
      chk("t1_gid", 32'(gq[i]), 32'd2);
    end
    chk("t1_burst_run", 32'(wt[3] - wt[0]), 32'd3);
    chk("t1_bubble", 32'(wt[4] - wt[3]), 32'd2);
    chk("t1_occ", 32'(bus.occupancy), 32'd6);
    chk("t1_no_rd", 32'(rd_cnt), 32'd0);

    // all four producers continuously valid: grants 0,1,2,3,0, 4 writes each
    reset = 1'b1;
    for (int p = 0; p < NP; p++) p_lim[p] = 0;
    drive(); cycle(2);
    wq.delete(); gq.delete(); wt.delete();
    for (int p = 0; p < NP; p++) begin
      p_cnt[p] = 0; p_base[p] = 8'h40 + 8'(16 * p); p_lim[p] = 1000;
    end
    reset = 1'b0; drive(); #1;
    cycle(25);
    for (int p = 0; p < NP; p++) p_lim[p] = p_cnt[p];
    drive(); #1;
    cycle(4);
    chk("t2_count", 32'(wq.size()), 32'd20);
    for (int b = 0; b < 5; b++) begin
      for (int k = 0; k < 4; k++) begin
        chk("t2_gid", 32'(gq[4*b+k]), 32'(b % 4));
        chk("t2_data", 32'(wq[4*b+k]), 32'(p_base[b % 4] + 8'((b / 4) * 4 + k)));
      end
    end
    chk("t2_occ", 32'(bus.occupancy), 32'd20);

    // fill to DEPTH, then reads drain one burst
    p_lim[0] = p_cnt[0] + 100; drive(); #1;
    cycle(20);
    chk("t3_full", 32'(bus.occupancy), 32'd32);
    chk("t3_no_ready", 32'(bus.prod_ready), 32'h0);
    p_lim[0] = p_cnt[0]; bus.cons_req = 1'b1; drive(); #1;
    rd0 = rd_cnt;
    cycle(1);
    chk("t3_cready", 32'(bus.cons_ready), 32'h1);
    cycle(4);
    bus.cons_req = 1'b0; #1;
    cycle(3);
    chk("t3_rd_pulses", 32'(rd_cnt - rd0), 32'd4);
    chk("t3_occ", 32'(bus.occupancy), 32'd28);

    // almost full with both sides pending: read goes first
    p_lim[1] = p_cnt[1] + 1; drive(); #1;
    cycle(5);
    chk("t4_occ29", 32'(bus.occupancy), 32'd29);
    n0 = wq.size();
    bus.cons_req = 1'b1; p_lim[3] = p_cnt[3] + 2; drive(); #1;
    cycle(1);
    chk("t4_rd_first", 32'(bus.cons_ready), 32'h1);
    chk("t4_no_pready", 32'(bus.prod_ready), 32'h0);
    cycle(1);
    chk("t4_rd_req", 32'(bus.fifo_rd_req), 32'h1);
    chk("t4_no_wr", 32'(bus.fifo_wr_en), 32'h0);
    chk("t4_occ28", 32'(bus.occupancy), 32'd28);
    bus.cons_req = 1'b0; #1;
    cycle(8);
    chk("t4_occ30", 32'(bus.occupancy), 32'd30);
    chk("t4_writes", 32'(wq.size() - n0), 32'd2);
    chk("t4_last_data", 32'(wq[$]), 32'h75);
    chk("t4_last_gid", 32'(gq[$]), 32'd3);

    // reset in the middle of a write burst
    p_lim[0] = p_cnt[0] + 10; drive(); #1;
    cycle(2);
    chk("t5_wr_en", 32'(bus.fifo_wr_en), 32'h1);
    chk("t5_occ31", 32'(bus.occupancy), 32'd31);
    reset = 1'b1; #1;
    chk("t5_rst_pready", 32'(bus.prod_ready), 32'h0);
    cycle(1);
    chk("t5_wr_en0", 32'(bus.fifo_wr_en), 32'h0);
    chk("t5_rd_req0", 32'(bus.fifo_rd_req), 32'h0);
    chk("t5_occ0", 32'(bus.occupancy), 32'd0);
    chk("t5_gid0", 32'(bus.grant_id), 32'd0);
    reset = 1'b0; #1;
    cycle(1);
    chk("t5_post_wr", 32'(bus.fifo_wr_en), 32'h0);
    chk("t5_post_rd", 32'(bus.fifo_rd_req), 32'h0);
    chk("t5_post_pready", 32'(bus.prod_ready), 32'h1);
    p_lim[0] = p_cnt[0]; drive(); #1;
    cycle(3);
    chk("t5_occ_end", 32'(bus.occupancy), 32'd0);

    // read request while empty is never accepted
    rd0 = rd_cnt;
    bus.cons_req = 1'b1; #1;
    cycle(1);
    chk("t6_cready0", 32'(bus.cons_ready), 32'h0);
    cycle(4);
    chk("t6_no_rd", 32'(rd_cnt - rd0), 32'd0);
    chk("t6_occ", 32'(bus.occupancy), 32'd0);
    bus.cons_req = 1'b0; #1;

`ifdef FIFO_SCHED_CHECK_EN
    chk("t7_err_clean", 32'(bus.sched_err), 32'h0);
    force_e = 1'b1; #1;
    cycle(1);
    chk("t7_err_set", 32'(bus.sched_err), 32'h1);
    force_e = 1'b0; #1;
    cycle(3);
    chk("t7_err_sticky", 32'(bus.sched_err), 32'h1);
    reset = 1'b1; #1;
    cycle(1);
    chk("t7_err_reset", 32'(bus.sched_err), 32'h0);
    reset = 1'b0; #1;
    cycle(1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
